// File: rtl/tt_mux_pkg.sv
// Shared constants, state enum and helpers for the muxperiment
// project-selection controller (tt_mux_ctrl and tt_mux_ow_select).
package tt_mux_pkg;

  localparam int IW_W       = 18;
  localparam int OW_W       = 24;
  localparam int IW_CLK     = 0;
  localparam int IW_RST_N   = 1;
  localparam int IW_UI_LSB  = 2;
  localparam int IW_UIO_LSB = 10;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESET  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt_mux_ow_select.sv
// Output-side slice mux: picks project sel_i's 24-bit bus from ow_i,
// gated to zero when en_i is low.
// Ports: sel_i (index), en_i (gate), ow_i (flattened buses), ow_o (pads).
// Macro TT_MUX_CTRL_OUT_REG_EN adds clk/rst ports and an output register.
module tt_mux_ow_select
  import tt_mux_pkg::*;
#(
  parameter int NUM_PROJ = 16,
  parameter int ADDR_W   = 4
) (
`ifdef TT_MUX_CTRL_OUT_REG_EN
  input  logic                     clk,
  input  logic                     rst,
`endif
  input  logic [ADDR_W-1:0]        sel_i,
  input  logic                     en_i,
  input  logic [NUM_PROJ*OW_W-1:0] ow_i,
  output logic [OW_W-1:0]          ow_o
);

  logic [OW_W-1:0] ow_d;

  always_comb begin
    ow_d = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (en_i && sel_i == ADDR_W'(k)) begin
        ow_d = ow_i[k*OW_W +: OW_W];
      end
    end
  end

`ifdef TT_MUX_CTRL_OUT_REG_EN
  logic [OW_W-1:0] ow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ow_q <= '0;
    end else begin
      ow_q <= ow_d;
    end
  end

  assign ow_o = ow_q;
`else
  assign ow_o = ow_d;
`endif

endmodule

// File: rtl/tt_mux_ctrl.sv
// Project-selection controller: accepts select/off requests, sequences
// drain gap -> held project reset -> live, drives one-hot proj_ena,
// broadcasts pad inputs (rst_n gated) and returns the selected outputs.
// Ports: clk, rst (async high), sel_* handshake, pad_iw/proj_iw,
// proj_ena, proj_ow/pad_ow, active_addr, busy.
// Macro TT_MUX_CTRL_OUT_REG_EN registers pad_ow.
module tt_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int NUM_PROJ   = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 2,
  parameter int RST_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel_valid,
  output logic                     sel_ready,
  input  logic [ADDR_W-1:0]        sel_addr,
  input  logic                     sel_off,
  output logic                     sel_err,
  input  logic [IW_W-1:0]          pad_iw,
  output logic [IW_W-1:0]          proj_iw,
  output logic [NUM_PROJ-1:0]      proj_ena,
  input  logic [NUM_PROJ*OW_W-1:0] proj_ow,
  output logic [OW_W-1:0]          pad_ow,
  output logic [ADDR_W-1:0]        active_addr,
  output logic                     busy
);

  localparam int CNT_MAX = max_int(GAP_CYCLES, RST_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              off_q, off_d;
  logic              err_q, err_d;

  logic              accept;
  logic              live;
  logic              ena_on;
  logic [2**ADDR_W-1:0] ok_map;

  // Constant table of in-range addresses.
  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_ok
    assign ok_map[i] = (i < NUM_PROJ);
  end

  assign accept = sel_valid & sel_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end

  // off_q remembers whether the drain ends in OFF or in RESET.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_OFF, ST_ACTIVE: begin
        if (accept) begin
          if (sel_off) begin
            state_d = ST_DRAIN;
            cnt_d   = GAP_LD;
            off_d   = 1'b1;
          end else if (!ok_map[sel_addr]) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = GAP_LD;
            off_d   = 1'b0;
            addr_d  = sel_addr;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          if (off_q) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            state_d = ST_RESET;
            cnt_d   = RST_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESET: begin
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    sel_ready = (state_q == ST_OFF) || (state_q == ST_ACTIVE);
    busy      = (state_q == ST_DRAIN) || (state_q == ST_RESET);
    live      = (state_q == ST_ACTIVE);
    ena_on    = (state_q == ST_RESET) || (state_q == ST_ACTIVE);
    for (int k = 0; k < NUM_PROJ; k++) begin
      proj_ena[k] = ena_on && (addr_q == ADDR_W'(k));
    end
  end

  // Project rst_n is held low until the project is live.
  assign proj_iw = {pad_iw[IW_W-1:IW_RST_N+1],
                    pad_iw[IW_RST_N] & live,
                    pad_iw[IW_CLK]};

  assign sel_err     = err_q;
  assign active_addr = addr_q;

  tt_mux_ow_select #(
    .NUM_PROJ (NUM_PROJ),
    .ADDR_W   (ADDR_W)
  ) u_ow_select (
`ifdef TT_MUX_CTRL_OUT_REG_EN
    .clk   (clk),
    .rst   (rst),
`endif
    .sel_i (addr_q),
    .en_i  (live),
    .ow_i  (proj_ow),
    .ow_o  (pad_ow)
  );

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Scoreboard bench for tt_mux_ctrl (NUM_PROJ=12 so out-of-range
// selects exist): a timeline model predicts per-cycle state.
module tb_tt_mux_ctrl;

  localparam int NP  = 12;
  localparam int AW  = 4;
  localparam int GAP = 2;
  localparam int RST = 8;

  localparam int M_OFF = 0;
  localparam int M_DRN = 1;
  localparam int M_RST = 2;
  localparam int M_ACT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sel_valid = 1'b0;
  logic             sel_ready;
  logic [AW-1:0]    sel_addr = '0;
  logic             sel_off = 1'b0;
  logic             sel_err;
  logic [17:0]      pad_iw = '0;
  logic [17:0]      proj_iw;
  logic [NP-1:0]    proj_ena;
  logic [NP*24-1:0] proj_ow = '0;
  logic [23:0]      pad_ow;
  logic [AW-1:0]    active_addr;
  logic             busy;

  tt_mux_ctrl #(
    .NUM_PROJ   (NP),
    .ADDR_W     (AW),
    .GAP_CYCLES (GAP),
    .RST_CYCLES (RST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel_valid   (sel_valid),
    .sel_ready   (sel_ready),
    .sel_addr    (sel_addr),
    .sel_off     (sel_off),
    .sel_err     (sel_err),
    .pad_iw      (pad_iw),
    .proj_iw     (proj_iw),
    .proj_ena    (proj_ena),
    .proj_ow     (proj_ow),
    .pad_ow      (pad_ow),
    .active_addr (active_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int addr;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since the accepting edge decide
  // the phase (1..GAP drain, then RST cycles of reset, then live).
  int seq_k   = 0;
  bit tgt_off = 0;
  bit m_live  = 0;
  int m_addr  = 0;

  function automatic int mode_now();
    if (seq_k == 0) return m_live ? M_ACT : M_OFF;
    if (seq_k <= GAP) return M_DRN;
    return M_RST;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        seq_k = 0; tgt_off = 0; m_live = 0; m_addr = 0;
        exp_q.delete();
      end else begin
        exp_t e;
        bit   err;
        err = 0;
        if (seq_k > 0) begin
          seq_k++;
          if (tgt_off && seq_k > GAP) begin
            seq_k = 0; m_live = 0;
          end else if (!tgt_off && seq_k > GAP + RST) begin
            seq_k = 0; m_live = 1;
          end
        end else if (sel_valid) begin
          if (sel_off) begin
            seq_k = 1; tgt_off = 1;
          end else if (int'(sel_addr) >= NP) begin
            err = 1;
          end else begin
            seq_k = 1; tgt_off = 0; m_addr = int'(sel_addr);
          end
        end
        e.mode = mode_now();
        e.addr = m_addr;
        e.err  = err;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  logic [23:0] prev_comb = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_comb = '0;
        chk("rst_ena",   64'(proj_ena), 64'd0);
        chk("rst_padow", 64'(pad_ow), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_err",   64'(sel_err), 64'd0);
        chk("rst_addr",  64'(active_addr), 64'd0);
        chk("rst_ready", 64'(sel_ready), 64'd1);
        chk("rst_iw1",   64'(proj_iw[1]), 64'd0);
      end else if (exp_q.size() > 0) begin
        exp_t        e;
        logic [NP-1:0] x_ena;
        logic [17:0] x_iw;
        logic [23:0] x_comb;
        logic [23:0] x_pad;
        e = exp_q.pop_front();
        x_ena = '0;
        if (e.mode == M_RST || e.mode == M_ACT) x_ena[e.addr] = 1'b1;
        x_iw = pad_iw;
        x_iw[1] = pad_iw[1] & (e.mode == M_ACT);
        x_comb = (e.mode == M_ACT) ? proj_ow[e.addr*24 +: 24] : 24'd0;
`ifdef TT_MUX_CTRL_OUT_REG_EN
        x_pad = prev_comb;
`else
        x_pad = x_comb;
`endif
        prev_comb = x_comb;
        chk("ena",   64'(proj_ena), 64'(x_ena));
        chk("busy",  64'(busy), 64'(e.mode == M_DRN || e.mode == M_RST));
        chk("ready", 64'(sel_ready), 64'(e.mode == M_OFF || e.mode == M_ACT));
        chk("err",   64'(sel_err), 64'(e.err));
        chk("addr",  64'(active_addr), 64'(e.addr));
        chk("iw",    64'(proj_iw), 64'(x_iw));
        chk("padow", 64'(pad_ow), 64'(x_pad));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    pad_iw = 18'($urandom);
    for (int k = 0; k < NP; k++) proj_ow[k*24 +: 24] = 24'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic req(input bit off, input int a);
    sel_valid = 1'b1;
    sel_off   = off;
    sel_addr  = AW'(a);
    step();
    sel_valid = 1'b0;
    sel_off   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    req(0, 3);
    idle(14);
    req(0, 13);
    idle(3);
    req(0, 5);
    idle(14);
    req(1, 0);
    idle(4);
    req(0, 3);
    idle(5);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    req(0, 7);
    idle(14);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end
      sel_valid = ($urandom_range(0, 99) < 40);
      sel_off   = ($urandom_range(0, 99) < 15);
      sel_addr  = AW'($urandom_range(0, 15));
      step();
    end
    sel_valid = 1'b0;
    sel_off   = 1'b0;
    idle(14);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_mux_ctrl.md
# tt_mux_ctrl

Project-selection controller for the muxperiment array. It accepts a select request over a valid/ready handshake and drives a one-hot `ena` to the project wrappers. It sequences a safe switch-over (drain gap, held project reset, then live) and broadcasts the packed 18-bit pad input bus to all wrappers. It also returns the selected wrapper's 24-bit output bus to the pads.

## Interface
- `NUM_PROJ`, 16: number of wrapped projects (2..2**ADDR_W).
- `ADDR_W`, 4: select address width.
- `GAP_CYCLES`, 2: cycles with no project enabled between deselect and reselect (≥1).
- `RST_CYCLES`, 8: cycles the new project's `rst_n` bit is held low after `ena` rises (≥1).

Ports:
- `clk` in 1: controller clock.
- `rst` in 1: asynchronous, active-high reset.
- `sel_valid` in 1: select request valid.
- `sel_ready` out 1: controller can accept a request.
- `sel_addr` in ADDR_W: project index requested.
- `sel_off` in 1: when set with a request, the request deselects all projects (`sel_addr` ignored).
- `sel_err` out 1: one-cycle pulse, request rejected.
- `pad_iw` in 18: packed pad inputs {uio_in[7:0], ui_in[7:0], rst_n, clk}.
- `proj_iw` out 18: bus broadcast to all wrappers.
- `proj_ena` out NUM_PROJ: one-hot project enable.
- `proj_ow` in NUM_PROJ*24: flattened wrapper outputs; project k occupies [24k+23:24k], layout {uio_oe, uio_out, uo_out}.
- `pad_ow` out 24: selected project output to pads.
- `active_addr` out ADDR_W: last accepted project index.
- `busy` out 1: high in DRAIN or RESET.

## Operation
- FSM states: OFF, DRAIN, RESET, ACTIVE.
- Reset values: state OFF, `proj_ena`=0, `pad_ow`=0, `active_addr`=0, `sel_err`=0, `busy`=0, counter=0.
- `sel_ready` is 1 in OFF and ACTIVE, and 0 otherwise. A request is accepted on a rising edge with `sel_valid & sel_ready`.
- Invalid request: `sel_addr` ≥ NUM_PROJ with `sel_off`=0. The controller pulses `sel_err` for one cycle and changes no other state.
- Valid select from OFF or ACTIVE:
  - Latch `active_addr` and go to DRAIN.
  - DRAIN lasts GAP_CYCLES cycles with `proj_ena`=0.
  - Then RESET for RST_CYCLES cycles, with `proj_ena[active_addr]`=1.
  - Then ACTIVE.
- Reselecting the currently active index still performs the full DRAIN/RESET sequence.
- `sel_off` request: go to DRAIN for GAP_CYCLES, then OFF. `active_addr` is unchanged.
- `proj_iw`:
  - equals `pad_iw` except bit 1 (`rst_n`).
  - Bit 1 follows `pad_iw[1]` only in ACTIVE. It is forced 0 in OFF, DRAIN and RESET.
  - Bit 0 (`clk`) always passes through combinationally.
- `pad_ow` equals the `active_addr` slice of `proj_ow` in ACTIVE. It is 0 in all other states.
- The down-counter is sized for max(GAP_CYCLES, RST_CYCLES). It is reloaded on every state entry.

## Timing
- An accept at edge E gives DRAIN during cycles E+1..E+GAP_CYCLES.
- RESET runs from E+GAP_CYCLES+1 for RST_CYCLES cycles.
- ACTIVE begins GAP_CYCLES+RST_CYCLES+1 cycles after E. With defaults that is cycle E+11.
- `sel_err` is asserted in the cycle after the rejecting edge.
- `rst` asserted at any point, including mid-DRAIN or mid-RESET: outputs return to reset values immediately (asynchronous), and any in-flight request is dropped.
- After `rst` is released, the first edge can accept a request.
- `sel_valid` held while `sel_ready`=0 is not accepted. It is accepted on the first edge after the controller returns to ACTIVE or OFF.

## Configuration
- `TT_MUX_CTRL_OUT_REG_EN`:
  - Defined: `pad_ow` is registered. It shows the selected slice one cycle after the combinational value, resets to 0, and is cleared in the cycle after ACTIVE is left.
  - Undefined: `pad_ow` is a combinational mux gated by the ACTIVE state.

## Structure
- Package `tt_mux_pkg` holds:
  - IW_W=18, OW_W=24;
  - bit indices IW_CLK=0, IW_RST_N=1, IW_UI_LSB=2, IW_UIO_LSB=10;
  - the state enum.
- One sub-module, `tt_mux_ow_select`: a parameterized NUM_PROJ×24 slice mux with an enable gate, and the optional output register.

## Test plan
- Reset, then select 3 with NUM_PROJ=16:
  - `sel_ready` drops;
  - `proj_ena`=0 for 2 cycles, then 16'h0008;
  - `proj_iw[1]`=0 for 8 cycles;
  - ACTIVE at E+11;
  - `pad_ow` = `proj_ow[95:72]`.
- With NUM_PROJ=12, select 13: `sel_err` pulses once, and `proj_ena`, `busy` and `active_addr` are unchanged.
- Switch from project 3 to 5 in ACTIVE: `pad_ow`=0 and `proj_ena`=0 during DRAIN, then `proj_ena`=16'h0020, then project 5's data appears.
- `sel_off` from ACTIVE: after 2 DRAIN cycles the state is OFF, `proj_ena`=0, `pad_ow`=0, and `sel_ready`=1.
- Assert `rst` during RESET, at cycle 4 of 8: `proj_ena`, `pad_ow` and `busy` are 0 in the same cycle. After release, a new select completes normally.
- With `TT_MUX_CTRL_OUT_REG_EN` defined: `pad_ow` lags the combinational build by exactly one cycle on entry to ACTIVE and on exit from it.
